phrase_sequencer: RTL



---
 rtl/phrase_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/phrase_sequencer.sv
// Phrase ROM playback controller: walks phrases, steps notes on a tick-based duration counter.
// Optional looping playback is enabled by defining PHRASE_SEQ_LOOP_EN.
module phrase_sequencer #(
    parameter int unsigned TICK_DIV    = 1500,
    parameter int unsigned LAST_PHRASE = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    output logic [3:0]  phrase_addr,
    input  logic [31:0] db_entry,
    input  logic [7:0]  length_entry,
    input  logic [2:0]  n_note,
    output logic [3:0]  note_code,
    output logic        gate,
    output logic        note_strobe,
    output logic [3:0]  phrase_idx,
    output logic        busy,
    output logic        done
);

`ifdef PHRASE_SEQ_LOOP_EN
    localparam bit LoopEn = 1'b1;
`else
    localparam bit LoopEn = 1'b0;
`endif

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(2 * TICK_DIV) : 1;
    localparam logic [CntW-1:0] ShortLast = CntW'(TICK_DIV - 1);
    localparam logic [CntW-1:0] LongLast  = CntW'(2 * TICK_DIV - 1);
    localparam logic [3:0]      LastAddr  = 4'(LAST_PHRASE);
    localparam logic [3:0]      RestCode  = 4'd7;

    typedef enum logic [1:0] {StIdle, StLoad, StPlay, StDone} state_e;

    state_e          state_q;
    logic [3:0]      phrase_addr_q;
    logic [3:0]      phrase_idx_q;
    logic [31:0]     db_q;
    logic [7:0]      len_q;
    logic [2:0]      nn_q;
    logic [2:0]      ptr_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      note_code_q;
    logic            gate_q;
    logic            strobe_q;
    logic            busy_q;
    logic            done_q;

    logic [CntW-1:0] cnt_last;
    logic            note_end;
    logic            phrase_end;
    logic [2:0]      nxt_ptr;
    logic [3:0]      nxt_code;
    logic [3:0]      rom_code;
    logic [3:0]      addr_inc;

    // Note 0 sits in the top nibble / top length bit, so index with the inverted pointer.
    always_comb begin
        cnt_last   = len_q[~ptr_q] ? LongLast : ShortLast;
        note_end   = (cnt_q == cnt_last);
        phrase_end = (ptr_q == nn_q);
        nxt_ptr    = ptr_q + 3'd1;
        nxt_code   = db_q[{~nxt_ptr, 2'b00} +: 4];
        rom_code   = db_entry[31:28];
        if (LoopEn && (phrase_addr_q == LastAddr)) begin
            addr_inc = 4'd0;
        end else begin
            addr_inc = phrase_addr_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            phrase_addr_q <= 4'd0;
            phrase_idx_q  <= 4'd0;
            db_q          <= 32'd0;
            len_q         <= 8'd0;
            nn_q          <= 3'd0;
            ptr_q         <= 3'd0;
            cnt_q         <= '0;
            note_code_q   <= 4'd0;
            gate_q        <= 1'b0;
            strobe_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else if (stop) begin
            state_q       <= StIdle;
            phrase_addr_q <= 4'd0;
            phrase_idx_q  <= 4'd0;
            ptr_q         <= 3'd0;
            cnt_q         <= '0;
            note_code_q   <= 4'd0;
            gate_q        <= 1'b0;
            strobe_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q       <= StLoad;
                        phrase_addr_q <= 4'd0;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                    end
                end
                StLoad: begin
                    db_q          <= db_entry;
                    len_q         <= length_entry;
                    nn_q          <= n_note;
                    ptr_q         <= 3'd0;
                    cnt_q         <= '0;
                    phrase_idx_q  <= phrase_addr_q;
                    phrase_addr_q <= addr_inc;
                    note_code_q   <= rom_code;
                    gate_q        <= (rom_code != RestCode);
                    strobe_q      <= 1'b1;
                    state_q       <= StPlay;
                end
                StPlay: begin
                    strobe_q <= 1'b0;
                    if (!note_end) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else if (!phrase_end) begin
                        ptr_q       <= nxt_ptr;
                        cnt_q       <= '0;
                        note_code_q <= nxt_code;
                        gate_q      <= (nxt_code != RestCode);
                        strobe_q    <= 1'b1;
                    end else if (LoopEn || (phrase_idx_q < LastAddr)) begin
                        // Seamless phrase change: ROM already shows the next entry.
                        db_q          <= db_entry;
                        len_q         <= length_entry;
                        nn_q          <= n_note;
                        ptr_q         <= 3'd0;
                        cnt_q         <= '0;
                        phrase_idx_q  <= phrase_addr_q;
                        phrase_addr_q <= addr_inc;
                        note_code_q   <= rom_code;
                        gate_q        <= (rom_code != RestCode);
                        strobe_q      <= 1'b1;
                    end else begin
                        state_q     <= StDone;
                        ptr_q       <= 3'd0;
                        cnt_q       <= '0;
                        note_code_q <= 4'd0;
                        gate_q      <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign phrase_addr = phrase_addr_q;
    assign phrase_idx  = phrase_idx_q;
    assign note_code   = note_code_q;
    assign gate        = gate_q;
    assign note_strobe = strobe_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
